// File: rtl/valid_delay_line_pkg.sv
// valid_delay_line_pkg
//   Shared helpers for the valid-tagged delay line:
//   - tap_width / occ_width : derive the tap select and occupancy widths
//     from the stage count.
//   - STAGE_RESET           : value a stage takes on reset or flush.
//   No ports (package).
package valid_delay_line_pkg;

  // A single stage still needs a 1-bit select port.
  function automatic int tap_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy has to represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int STAGE_RESET = 0;

endpackage

// File: rtl/valid_delay_line_delay_stage.sv
// delay_stage
//   One register of the delay line. Carries {valid, data} as a single
//   W-bit word.
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous active-high clear
//   flush  in   1  synchronous clear (same effect as rst, lower priority)
//   hold   in   1  keep current value
//   d      in   W  next value when not cleared or held
//   q      out  W  registered value
module delay_stage
  import valid_delay_line_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= W'(STAGE_RESET);
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/valid_delay_line.sv
// valid_delay_line
//   Valid-tagged delay line of DEPTH registered stages with stall, flush,
//   a combinational tap readout and a registered occupancy counter.
//   Latency input -> out_* is DEPTH cycles (stage DEPTH-1).
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      capture in_data this cycle
//   in_data    in   WIDTH  input sample
//   stall      in   1      hold every stage, input ignored
//   flush      in   1      clear every stage, input dropped
//   tap_sel    in   TW     stage index for tap readout (0 = newest)
//   out_valid  out  1      valid of stage DEPTH-1
//   out_data   out  WIDTH  data of stage DEPTH-1
//   tap_valid  out  1      valid of stage tap_sel, 0 when out of range
//   tap_data   out  WIDTH  data of stage tap_sel, 0 when out of range
//   occupancy  out  CW     number of valid stages
module valid_delay_line
  import valid_delay_line_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int TW = tap_width(DEPTH),
  localparam int CW = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  input  logic [TW-1:0]    tap_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             tap_valid,
  output logic [WIDTH-1:0] tap_data,
  output logic [CW-1:0]    occupancy
);

  // Each stage word is {valid, data}; valid sits in bit WIDTH.
  logic [WIDTH:0] stage_q [DEPTH];
  logic [WIDTH:0] head_word;
  logic [WIDTH:0] tap_word;
  logic [CW-1:0]  occ_q;

  // Bubbles enter with zero data so nothing stale travels down the chain.
  assign head_word = {in_valid, in_valid ? in_data : WIDTH'(0)};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      delay_stage #(.W(WIDTH + 1)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .hold  (stall),
        .d     (head_word),
        .q     (stage_q[0])
      );
    end else begin : g_body
      delay_stage #(.W(WIDTH + 1)) u_stage (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .hold  (stall),
        .d     (stage_q[i-1]),
        .q     (stage_q[i])
      );
    end
  end

  if (DEPTH == 1) begin : g_tap_single
    // Only one stage exists, so the select is irrelevant.
    logic unused_tap_sel;
    assign unused_tap_sel = ^tap_sel;
    assign tap_word = stage_q[0];
  end else begin : g_tap_mux
    // Non-power-of-2 depths leave select codes with no stage behind them.
    always_comb begin
      tap_word = '0;
      if (int'(tap_sel) < DEPTH) begin
        tap_word = stage_q[tap_sel];
      end
    end
  end

  // Tracks entries minus exits instead of counting valid bits each cycle;
  // a simultaneous entry and exit cancels out.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else if (!stall) begin
      occ_q <= occ_q + CW'(in_valid) - CW'(stage_q[DEPTH-1][WIDTH]);
    end
  end

  assign out_valid = stage_q[DEPTH-1][WIDTH];
  assign out_data  = stage_q[DEPTH-1][WIDTH-1:0];
  assign tap_valid = tap_word[WIDTH];
  assign tap_data  = tap_word[WIDTH-1:0];
  assign occupancy = occ_q;

endmodule
